if_fetch_unit: RTL and testbench

Parametrised instruction-fetch unit that replaces the combinational PC+4 fetch path. It issues in-order fetch requests over a valid/ready memory port and tracks outstanding requests with credits. Returned instructions are buffered in a prefetch FIFO and handed to decode over a valid/ready handshake. A redirect (branch/jump/trap) flushes the FIFO, retargets fetch and silently drops stale in-flight responses.

---
 rtl/if_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: credit-limited in-order fetch requests, a prefetch
// FIFO of {pc, instr, err} toward decode, and redirect handling that flushes
// the FIFO and silently drops responses to stale in-flight requests.
module if_fetch_unit #(
    parameter int              XLEN       = 64,
    parameter int              ILEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h8000_0000,
    parameter int              FIFO_DEPTH = 4,
    localparam int             CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_rsp_valid_i,
    input  logic [ILEN-1:0] mem_rsp_data_i,
    input  logic            mem_rsp_err_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_err_o
);

    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [XLEN-1:0] pc_mem  [FIFO_DEPTH];
    logic [ILEN-1:0] ins_mem [FIFO_DEPTH];
    logic            err_mem [FIFO_DEPTH];

    logic [XLEN-1:0] redirect_pc_al;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic [1:0]      unused_redirect_lsbs;

    // Low address bits of a redirect target are ignored.
    assign unused_redirect_lsbs = redirect_pc_i[1:0];
    assign redirect_pc_al       = {redirect_pc_i[XLEN-1:2], 2'b00};

    // Every in-flight request owns a FIFO slot, so the FIFO can never overflow.
    // The request is forced low while reset is held so all outputs stay quiet.
    assign credit_ok       = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW+1)'(FIFO_DEPTH);
    assign mem_req_valid_o = rst_n && credit_ok && !redirect_i;
    assign mem_req_addr_o  = fetch_pc_q;
    assign req_fire        = mem_req_valid_o && mem_req_ready_i;

    // Responses while drop_cnt is non-zero belong to requests issued before a
    // redirect; a response in the redirect cycle itself is also stale.
    assign rsp_drop = (drop_cnt_q != '0);
    assign push     = mem_rsp_valid_i && !rsp_drop && !redirect_i;

    // Head fields are zeroed while empty so unwritten storage never leaks out.
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? ins_mem[rd_ptr_q] : '0;
    assign instr_pc_o    = instr_valid_o ? pc_mem[rd_ptr_q]  : '0;
    assign instr_err_o   = instr_valid_o ? err_mem[rd_ptr_q] : 1'b0;
    assign pop           = instr_valid_o && instr_ready_i;

    // Next-state for PCs, credit/drop counters and FIFO bookkeeping; redirect wins.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(mem_rsp_valid_i);
        drop_cnt_d = drop_cnt_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_al;
            rsp_pc_d   = redirect_pc_al;
            // Everything still outstanding after this cycle is stale.
            drop_cnt_d = inflight_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (mem_rsp_valid_i && rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage is data only; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= rsp_pc_q;
            ins_mem[wr_ptr_q] <= mem_rsp_data_i;
            err_mem[wr_ptr_q] <= mem_rsp_err_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory responses and decode handshakes
// are driven cycle by cycle with hand-derived expectations.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [63:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        mem_rsp_err_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [63:0] instr_pc_o;
    logic        instr_err_o;

    int checks   = 0;
    int failures = 0;

    if_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_err_i   (mem_rsp_err_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_err_o     (instr_err_o)
    );

    always #5 clk = ~clk;

    // Instruction word the bench's memory returns for a given address.
    function automatic logic [31:0] inst(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs (called just after a rising edge), then settle.
    task automatic drive(input logic rdy, input logic rv, input logic [31:0] d,
                         input logic e, input logic ir, input logic rd,
                         input logic [63:0] rp);
        mem_req_ready_i = rdy;
        mem_rsp_valid_i = rv;
        mem_rsp_data_i  = d;
        mem_rsp_err_i   = e;
        instr_ready_i   = ir;
        redirect_i      = rd;
        redirect_pc_i   = rp;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", mem_req_valid_o, 0);
        chk("rst_req_addr", mem_req_addr_o, 64'h8000_0000);
        chk("rst_instr_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_instr_pc", instr_pc_o, 0);
        chk("rst_instr_err", instr_err_o, 0);
        rst_n = 1'b1;

        // Streaming fetch with latency-1 memory
        drive(1, 0, 0, 0, 1, 0, 0);                                   // c0
        chk("c0_req_valid", mem_req_valid_o, 1);
        chk("c0_req_addr", mem_req_addr_o, 64'h8000_0000);
        chk("c0_instr_valid", instr_valid_o, 0);
        adv();
        drive(1, 1, inst(64'h8000_0000), 0, 1, 0, 0);                // c1
        chk("c1_req_addr", mem_req_addr_o, 64'h8000_0004);
        chk("c1_instr_valid", instr_valid_o, 0);
        adv();
        // Ready drops: address must hold at 0x8000_0008 for 5 cycles
        drive(0, 1, inst(64'h8000_0004), 0, 1, 0, 0);                // c2
        chk("c2_instr_valid", instr_valid_o, 1);
        chk("c2_instr_pc", instr_pc_o, 64'h8000_0000);
        chk("c2_instr", instr_o, inst(64'h8000_0000));
        chk("c2_req_addr", mem_req_addr_o, 64'h8000_0008);
        adv();
        drive(0, 0, 0, 0, 1, 0, 0);                                   // c3
        chk("c3_instr_pc", instr_pc_o, 64'h8000_0004);
        chk("c3_instr", instr_o, inst(64'h8000_0004));
        for (int i = 0; i < 4; i++) begin                             // c3..c6
            chk("stall_req_valid", mem_req_valid_o, 1);
            chk("stall_req_addr", mem_req_addr_o, 64'h8000_0008);
            adv();
            drive(0, 0, 0, 0, 1, 0, 0);
            chk("stall_instr_valid", instr_valid_o, 0);
        end
        drive(1, 0, 0, 0, 1, 0, 0);                                   // c7
        chk("c7_req_addr", mem_req_addr_o, 64'h8000_0008);
        chk("c7_req_valid", mem_req_valid_o, 1);
        adv();

        // Error response is buffered with its PC; fetch continues at PC+4
        drive(0, 1, inst(64'h8000_0008), 1, 0, 0, 0);                // c8
        chk("c8_req_addr", mem_req_addr_o, 64'h8000_000C);
        adv();
        drive(0, 0, 0, 0, 1, 0, 0);                                   // c9
        chk("err_instr_valid", instr_valid_o, 1);
        chk("err_instr_pc", instr_pc_o, 64'h8000_0008);
        chk("err_flag", instr_err_o, 1);
        chk("err_instr", instr_o, inst(64'h8000_0008));
        chk("err_next_addr", mem_req_addr_o, 64'h8000_000C);
        adv();

        // Decode stalled: exactly FIFO_DEPTH requests, then credit stops issue
        drive(1, 0, 0, 0, 0, 0, 0);                                   // c10
        chk("c10_instr_valid", instr_valid_o, 0);
        chk("c10_req_addr", mem_req_addr_o, 64'h8000_000C);
        adv();
        drive(1, 1, inst(64'h8000_000C), 0, 0, 0, 0); adv();          // c11
        drive(1, 1, inst(64'h8000_0010), 0, 0, 0, 0); adv();          // c12
        drive(1, 1, inst(64'h8000_0014), 0, 0, 0, 0);                 // c13
        chk("c13_req_valid", mem_req_valid_o, 1);
        adv();
        drive(1, 1, inst(64'h8000_0018), 0, 0, 0, 0);                 // c14
        chk("c14_req_valid", mem_req_valid_o, 0);
        adv();
        drive(1, 0, 0, 0, 0, 0, 0);                                   // c15
        chk("full_req_valid", mem_req_valid_o, 0);
        chk("full_req_addr", mem_req_addr_o, 64'h8000_001C);
        chk("full_head_pc", instr_pc_o, 64'h8000_000C);
        adv();
        drive(1, 0, 0, 0, 1, 0, 0);                                   // c16 pop
        chk("c16_req_valid", mem_req_valid_o, 0);
        adv();
        drive(1, 0, 0, 0, 0, 0, 0);                                   // c17
        chk("after_pop_req_valid", mem_req_valid_o, 1);
        chk("after_pop_req_addr", mem_req_addr_o, 64'h8000_001C);
        chk("after_pop_head_pc", instr_pc_o, 64'h8000_0010);
        adv();
        drive(1, 1, inst(64'h8000_001C), 0, 0, 0, 0);                 // c18
        chk("one_req_only", mem_req_valid_o, 0);
        adv();
        for (int i = 0; i < 4; i++) begin                             // c19..c22
            drive(0, 0, 0, 0, 1, 0, 0);
            chk("drain_pc", instr_pc_o, 64'h8000_0010 + 64'(4 * i));
            chk("drain_instr", instr_o, inst(64'h8000_0010 + 64'(4 * i)));
            adv();
        end

        // Redirect with 3 requests in flight
        drive(1, 0, 0, 0, 0, 0, 0);                                   // c23
        chk("c23_instr_valid", instr_valid_o, 0);
        chk("c23_req_addr", mem_req_addr_o, 64'h8000_0020);
        adv();
        drive(1, 0, 0, 0, 0, 0, 0); adv();                            // c24
        drive(1, 0, 0, 0, 0, 0, 0); adv();                            // c25
        drive(1, 0, 0, 0, 0, 1, 64'h8000_1002);                       // c26
        chk("redir_no_req", mem_req_valid_o, 0);
        adv();
        drive(0, 1, inst(64'h8000_0020), 0, 1, 0, 0);                 // c27
        chk("redir_addr", mem_req_addr_o, 64'h8000_1000);
        chk("redir_req_valid", mem_req_valid_o, 1);
        adv();
        drive(0, 1, inst(64'h8000_0024), 0, 1, 0, 0);                 // c28
        chk("stale1_dropped", instr_valid_o, 0);
        adv();
        drive(0, 1, inst(64'h8000_0028), 0, 1, 0, 0);                 // c29
        chk("stale2_dropped", instr_valid_o, 0);
        adv();
        drive(1, 0, 0, 0, 0, 0, 0);                                   // c30
        chk("stale3_dropped", instr_valid_o, 0);
        chk("c30_req_addr", mem_req_addr_o, 64'h8000_1000);
        adv();
        drive(0, 1, inst(64'h8000_1000), 0, 0, 0, 0); adv();          // c31
        drive(1, 0, 0, 0, 0, 0, 0);                                   // c32
        chk("redir_first_valid", instr_valid_o, 1);
        chk("redir_first_pc", instr_pc_o, 64'h8000_1000);
        chk("redir_first_instr", instr_o, inst(64'h8000_1000));
        adv();

        // Redirect coinciding with a response and a pop, 2 in flight
        drive(1, 0, 0, 0, 0, 0, 0); adv();                            // c33
        drive(1, 1, inst(64'h8000_1004), 0, 1, 1, 64'h8000_2000);     // c34
        chk("r2_no_req", mem_req_valid_o, 0);
        chk("r2_pop_valid", instr_valid_o, 1);
        chk("r2_pop_pc", instr_pc_o, 64'h8000_1000);
        adv();
        drive(0, 0, 0, 0, 1, 0, 0);                                   // c35
        chk("r2_fifo_empty", instr_valid_o, 0);
        chk("r2_addr", mem_req_addr_o, 64'h8000_2000);
        chk("r2_req_valid", mem_req_valid_o, 1);
        adv();
        drive(0, 1, inst(64'h8000_1008), 0, 1, 0, 0); adv();          // c36 stale
        drive(1, 0, 0, 0, 1, 0, 0);                                   // c37
        chk("r2_stale_dropped", instr_valid_o, 0);
        adv();
        drive(0, 1, inst(64'h8000_2000), 0, 0, 0, 0); adv();          // c38
        drive(0, 0, 0, 0, 0, 0, 0);                                   // c39
        chk("r2_first_valid", instr_valid_o, 1);
        chk("r2_first_pc", instr_pc_o, 64'h8000_2000);
        chk("r2_first_instr", instr_o, inst(64'h8000_2000));

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        chk("arst_instr_valid", instr_valid_o, 0);
        chk("arst_req_valid", mem_req_valid_o, 0);
        chk("arst_req_addr", mem_req_addr_o, 64'h8000_0000);
        chk("arst_instr_pc", instr_pc_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
